// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer
//   Final pixel stage of the VGA pipeline. Picks the highest-priority visible
//   layer for each pixel and forces black during blanking. It drives the
//   registered sync and colour pins.
//   Layer enables are shadowed. They load only on a vblank rising edge, so
//   toggling a layer never tears a frame.
//   Latency is 2 pclk cycles from every input to every output.
//
// Ports
//   pclk, rst                 pixel clock; synchronous active-high reset
//   hcount_in, vcount_in      pixel coordinates (11 bit)
//   hsync_in, vsync_in        sync strobes, polarity passed through unchanged
//   hblnk_in, vblnk_in        blanking strobes
//   layer_rgb                 LAYERS packed {r,g,b} words; layer k at [k*3*COLOR_W +: 3*COLOR_W]
//   layer_valid               per-layer opaque-pixel flags
//   layer_en                  requested layer enables (shadowed)
//   hcount_out, vcount_out    counts delayed to line up with r/g/b
//   hs, vs                    registered sync pins
//   r, g, b                   registered colour pins
//   frame_start               one-cycle pulse on the output cycle of a vblank rise
//
// Configuration
//   VGA_MIX_TRANSP_KEY_EN     when defined, a layer whose colour equals
//                             KEY_COLOR is treated as transparent.
module vga_layer_mixer #(
  parameter int                   LAYERS    = 2,
  parameter int                   COLOR_W   = 4,
  parameter logic [3*COLOR_W-1:0] BG_COLOR  = '0,
  parameter logic [3*COLOR_W-1:0] KEY_COLOR = 12'hF0F
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic [10:0]                   hcount_in,
  input  logic [10:0]                   vcount_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          hblnk_in,
  input  logic                          vblnk_in,
  input  logic [LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic [LAYERS-1:0]             layer_valid,
  input  logic [LAYERS-1:0]             layer_en,
  output logic [10:0]                   hcount_out,
  output logic [10:0]                   vcount_out,
  output logic                          hs,
  output logic                          vs,
  output logic [COLOR_W-1:0]            r,
  output logic [COLOR_W-1:0]            g,
  output logic [COLOR_W-1:0]            b,
  output logic                          frame_start
);

  localparam int PIX_W = 3 * COLOR_W;

`ifdef VGA_MIX_TRANSP_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic              vblnk_prev;
  logic [LAYERS-1:0] en_act;
  logic              vblnk_rise;
  logic [LAYERS-1:0] vis;
  logic [PIX_W-1:0]  sel_rgb;

  // stage 1
  logic [PIX_W-1:0]  s1_rgb;
  logic              s1_blank;
  logic              s1_hs;
  logic              s1_vs;
  logic [10:0]       s1_hc;
  logic [10:0]       s1_vc;
  logic              s1_rise;

  assign vblnk_rise = vblnk_in & ~vblnk_prev;

  // Visibility uses the enables in force for this pixel. An enable update
  // loaded on this same edge applies from the next pixel.
  always_comb begin
    vis     = '0;
    sel_rgb = BG_COLOR;
    for (int k = 0; k < LAYERS; k++) begin
      vis[k] = layer_valid[k] & en_act[k] &
               ~(KEY_EN & (layer_rgb[k*PIX_W +: PIX_W] == KEY_COLOR));
    end
    // Ascending scan, so the highest visible index is assigned last and wins.
    for (int k = 0; k < LAYERS; k++) begin
      if (vis[k]) sel_rgb = layer_rgb[k*PIX_W +: PIX_W];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev  <= 1'b0;
      en_act      <= '1;
      s1_rgb      <= '0;
      s1_blank    <= 1'b0;
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_hc       <= '0;
      s1_vc       <= '0;
      s1_rise     <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hs          <= 1'b0;
      vs          <= 1'b0;
      hcount_out  <= '0;
      vcount_out  <= '0;
      frame_start <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_rise) en_act <= layer_en;

      s1_rgb   <= sel_rgb;
      s1_blank <= hblnk_in | vblnk_in;
      s1_hs    <= hsync_in;
      s1_vs    <= vsync_in;
      s1_hc    <= hcount_in;
      s1_vc    <= vcount_in;
      s1_rise  <= vblnk_rise;

      {r, g, b}   <= s1_blank ? '0 : s1_rgb;
      hs          <= s1_hs;
      vs          <= s1_vs;
      hcount_out  <= s1_hc;
      vcount_out  <= s1_vc;
      frame_start <= s1_rise;
    end
  end

endmodule

// File: tb/tb_vga_layer_mixer.sv
module tb_vga_layer_mixer;

  localparam int          LAYERS  = 3;
  localparam int          COLOR_W = 4;
  localparam logic [11:0] BG      = 12'h05A;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [35:0] layer_rgb;
  logic [2:0]  layer_valid, layer_en;
  logic [10:0] hcount_out, vcount_out;
  logic        hs, vs, frame_start;
  logic [3:0]  r, g, b;
  logic [11:0] rgb;

  int errors = 0;
  int checks = 0;

  assign rgb = {r, g, b};

  always #5 pclk = ~pclk;

  vga_layer_mixer #(
    .LAYERS   (LAYERS),
    .COLOR_W  (COLOR_W),
    .BG_COLOR (BG),
    .KEY_COLOR(12'hF0F)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .layer_rgb  (layer_rgb),
    .layer_valid(layer_valid),
    .layer_en   (layer_en),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hs         (hs),
    .vs         (vs),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  logic [23:0] cur_tv, prev_tv;

  initial begin
    rst         = 1'b1;
    hcount_in   = 11'd100;
    vcount_in   = 11'd50;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    hblnk_in    = 1'b0;
    vblnk_in    = 1'b0;
    layer_rgb   = {12'h333, 12'h222, 12'h111};
    layer_valid = 3'b111;
    layer_en    = 3'b111;

    // reset held 3 cycles with live inputs
    repeat (3) tick();
    check("rst_rgb", rgb, 12'h000);
    check("rst_hs_vs", {hs, vs}, 2'b00);
    check("rst_fs", frame_start, 1'b0);
    check("rst_counts", {hcount_out, vcount_out}, 22'd0);

    rst = 1'b0;
    tick();
    check("post_rst_1cyc_rgb", rgb, 12'h000);
    check("post_rst_1cyc_hs", hs, 1'b0);
    tick();
    check("post_rst_2cyc_rgb", rgb, 12'h333);
    check("post_rst_2cyc_sync", {hs, vs}, 2'b11);
    check("post_rst_2cyc_cnt", {hcount_out, vcount_out}, {11'd100, 11'd50});

    // priority
    layer_valid = 3'b011; tick(); tick();
    check("prio_011", rgb, 12'h222);
    layer_valid = 3'b001; tick(); tick();
    check("prio_001", rgb, 12'h111);
    layer_valid = 3'b000; tick(); tick();
    check("prio_bg", rgb, BG);
    layer_valid = 3'b100; tick(); tick();
    check("prio_100", rgb, 12'h333);
    layer_valid = 3'b110; tick(); tick();
    check("prio_110", rgb, 12'h333);

    // hblank overrides a white layer; hs still tracks with 2-cycle delay
    layer_rgb   = {12'hFFF, 12'h222, 12'h111};
    layer_valid = 3'b100;
    hblnk_in    = 1'b1;
    hsync_in    = 1'b0;
    tick();
    check("hblnk_hs_1cyc", hs, 1'b1);
    tick();
    check("hblnk_rgb", rgb, 12'h000);
    check("hblnk_hs_2cyc", hs, 1'b0);
    hsync_in = 1'b1; tick(); tick();
    check("hblnk_hs_back", hs, 1'b1);
    layer_valid = 3'b000; tick(); tick();
    check("hblnk_over_bg", rgb, 12'h000);
    hblnk_in  = 1'b0;
    layer_rgb = {12'h333, 12'h222, 12'h111};

    // enable shadow: drop layer 2 mid-frame
    layer_valid = 3'b111;
    layer_en    = 3'b011;
    tick(); tick(); tick();
    check("shadow_mid_frame", rgb, 12'h333);
    vblnk_in = 1'b1;
    tick();
    check("fs_1cyc", frame_start, 1'b0);
    tick();
    check("fs_2cyc", frame_start, 1'b1);
    check("vblnk_rgb", rgb, 12'h000);
    tick();
    check("fs_once", frame_start, 1'b0);
    vblnk_in = 1'b0;
    layer_en = 3'b111;
    tick(); tick();
    check("shadow_new_frame", rgb, 12'h222);
    check("fs_quiet", frame_start, 1'b0);

    // colour key: layer 1 carries the key colour
    layer_rgb   = {12'h333, 12'hF0F, 12'h0A0};
    layer_valid = 3'b011;
    tick(); tick();
`ifdef VGA_MIX_TRANSP_KEY_EN
    check("key_on", rgb, 12'h0A0);
`else
    check("key_off", rgb, 12'hF0F);
`endif
    layer_rgb = {12'h333, 12'h222, 12'h111};

    // alignment under random timing inputs
    prev_tv = '0;
    for (int i = 0; i < 300; i++) begin
      hcount_in = 11'($urandom_range(0, 1343));
      vcount_in = 11'($urandom_range(0, 805));
      hsync_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      hblnk_in  = 1'($urandom_range(0, 1));
      vblnk_in  = 1'($urandom_range(0, 1));
      cur_tv    = {hcount_in, vcount_in, hsync_in, vsync_in};
      tick();
      if (i > 0) check("align", {hcount_out, vcount_out, hs, vs}, prev_tv);
      prev_tv = cur_tv;
    end

    // reload all enables, then reset mid-frame
    hblnk_in = 1'b0; vblnk_in = 1'b0; tick();
    vblnk_in = 1'b1; tick();
    vblnk_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    hcount_in = 11'd7; vcount_in = 11'd9;
    layer_valid = 3'b111;
    tick(); tick();
    check("pre_midrst_rgb", rgb, 12'h333);
    rst = 1'b1;
    tick();
    check("midrst_rgb", rgb, 12'h000);
    check("midrst_sync", {hs, vs}, 2'b00);
    check("midrst_cnt", {hcount_out, vcount_out}, 22'd0);
    rst = 1'b0;
    tick();
    check("midrst_flush", rgb, 12'h000);
    tick();
    check("midrst_resume", rgb, 12'h333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
